// File: rtl/arc4_pkg.sv
// Shared types and helpers for the ARC4 decrypt sequencer.
//   seq_state_t : sequencer states; each phase runs GO -> ARM -> WAIT.
//   owner_t     : which engine owns the S-memory write/address port.
//   owner_of    : phase owner for a state (the grant is a pure state decode).
//   next_of     : successor of a state on normal progress (handshake/exit).
//   is_go/is_wait : substates in which the watchdog counts.
package arc4_pkg;

  localparam int S_AW  = 8;
  localparam int S_DW  = 8;
  localparam int KEY_W = 24;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    INIT_GO   = 4'd1,
    INIT_ARM  = 4'd2,
    INIT_WAIT = 4'd3,
    KSA_GO    = 4'd4,
    KSA_ARM   = 4'd5,
    KSA_WAIT  = 4'd6,
    PRGA_GO   = 4'd7,
    PRGA_ARM  = 4'd8,
    PRGA_WAIT = 4'd9
  } seq_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_INIT = 2'd1,
    OWN_KSA  = 2'd2,
    OWN_PRGA = 2'd3
  } owner_t;

  function automatic owner_t owner_of(input seq_state_t s);
    case (s)
      INIT_GO, INIT_ARM, INIT_WAIT: owner_of = OWN_INIT;
      KSA_GO, KSA_ARM, KSA_WAIT:    owner_of = OWN_KSA;
      PRGA_GO, PRGA_ARM, PRGA_WAIT: owner_of = OWN_PRGA;
      default:                      owner_of = OWN_NONE;
    endcase
  endfunction

  function automatic seq_state_t next_of(input seq_state_t s);
    case (s)
      INIT_GO:   next_of = INIT_ARM;
      INIT_ARM:  next_of = INIT_WAIT;
      INIT_WAIT: next_of = KSA_GO;
      KSA_GO:    next_of = KSA_ARM;
      KSA_ARM:   next_of = KSA_WAIT;
      KSA_WAIT:  next_of = PRGA_GO;
      PRGA_GO:   next_of = PRGA_ARM;
      PRGA_ARM:  next_of = PRGA_WAIT;
      default:   next_of = IDLE;
    endcase
  endfunction

  function automatic logic is_go(input seq_state_t s);
    is_go = (s == INIT_GO) || (s == KSA_GO) || (s == PRGA_GO);
  endfunction

  function automatic logic is_wait(input seq_state_t s);
    is_wait = (s == INIT_WAIT) || (s == KSA_WAIT) || (s == PRGA_WAIT);
  endfunction

endpackage

// File: rtl/arc4_wdog.sv
// Per-phase watchdog counter.
//   clk_i, rst_n_i : clock, asynchronous active-low reset
//   clr_i          : zero the count (phase entry); wins over inc_i
//   inc_i          : count this cycle
//   expired_o      : count has reached TIMEOUT-1; never asserted when TIMEOUT=0
module arc4_wdog #(
  parameter int unsigned TIMEOUT = 32'd4096
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clr_i,
  input  logic inc_i,
  output logic expired_o
);
  // TIMEOUT-1 is the largest value ever compared, so clog2(TIMEOUT) bits suffice.
  localparam int unsigned CW = (TIMEOUT > 32'd1) ? $clog2(TIMEOUT) : 32'd1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign expired_o = (TIMEOUT != 32'd0) && (cnt_q == CW'(TIMEOUT - 32'd1));

  // Next count: clear on phase entry, otherwise count up and park at the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !expired_o) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/arc4_seq.sv
// Top-level sequencer for one ARC4 decrypt: init, then ksa, then prga.
// Grants the single-port S memory write/address port to the active engine.
// Optional feature macro: ARC4_CYCLE_COUNT_EN adds the 32-bit cycles_o counter.
//   clk_i, rst_n_i           : clock, asynchronous active-low reset
//   en_i / rdy_o             : task start request / idle flag
//   key_i / key_q_o          : key in / key latched at start (to ksa, prga)
//   err_o                    : last run aborted by the watchdog
//   <eng>_en_o / <eng>_rdy_i : engine start pulse / engine idle flag
//   <eng>_s_addr_i, _s_wrdata_i, _s_wren_i : engine S-memory port
//   s_addr_o, s_wrdata_o, s_wren_o         : granted S-memory port
//   cycles_o                 : busy-cycle count (ARC4_CYCLE_COUNT_EN only)
module arc4_seq
  import arc4_pkg::*;
#(
  parameter int unsigned TIMEOUT = 32'd4096
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             en_i,
  output logic             rdy_o,
  input  logic [KEY_W-1:0] key_i,
  output logic             err_o,
  output logic [KEY_W-1:0] key_q_o,
  output logic             init_en_o,
  output logic             ksa_en_o,
  output logic             prga_en_o,
  input  logic             init_rdy_i,
  input  logic             ksa_rdy_i,
  input  logic             prga_rdy_i,
  input  logic [S_AW-1:0]  init_s_addr_i,
  input  logic [S_DW-1:0]  init_s_wrdata_i,
  input  logic             init_s_wren_i,
  input  logic [S_AW-1:0]  ksa_s_addr_i,
  input  logic [S_DW-1:0]  ksa_s_wrdata_i,
  input  logic             ksa_s_wren_i,
  input  logic [S_AW-1:0]  prga_s_addr_i,
  input  logic [S_DW-1:0]  prga_s_wrdata_i,
  input  logic             prga_s_wren_i,
  output logic [S_AW-1:0]  s_addr_o,
  output logic [S_DW-1:0]  s_wrdata_o,
  output logic             s_wren_o
`ifdef ARC4_CYCLE_COUNT_EN
  ,
  output logic [31:0]      cycles_o
`endif
);

  seq_state_t       state_q, state_d;
  logic             err_q, err_d;
  logic [KEY_W-1:0] key_q, key_d;
  owner_t           owner_s;
  logic             cur_rdy_s;
  logic             start_s;
  logic             wd_clr_s, wd_inc_s, wd_exp_s;

  // The grant follows the registered state, so it is constant for a whole
  // phase and drops to NONE the instant the state returns to IDLE.
  assign owner_s   = owner_of(state_q);
  assign rdy_o     = (state_q == IDLE);
  assign err_o     = err_q;
  assign key_q_o   = key_q;
  assign init_en_o = (state_q == INIT_GO);
  assign ksa_en_o  = (state_q == KSA_GO);
  assign prga_en_o = (state_q == PRGA_GO);

  // Watchdog restarts on entry to any GO substate and counts only in GO/WAIT.
  assign wd_inc_s = is_go(state_q) || is_wait(state_q);
  assign wd_clr_s = is_go(state_d) && (state_d != state_q);

  arc4_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .clr_i     (wd_clr_s),
    .inc_i     (wd_inc_s),
    .expired_o (wd_exp_s)
  );

  // Idle flag of the engine that owns the current phase.
  always_comb begin
    case (owner_s)
      OWN_INIT: cur_rdy_s = init_rdy_i;
      OWN_KSA:  cur_rdy_s = ksa_rdy_i;
      OWN_PRGA: cur_rdy_s = prga_rdy_i;
      default:  cur_rdy_s = 1'b0;
    endcase
  end

  // S-memory port mux; a non-owner's write enable can never reach memory.
  always_comb begin
    s_addr_o   = '0;
    s_wrdata_o = '0;
    s_wren_o   = 1'b0;
    case (owner_s)
      OWN_INIT: begin
        s_addr_o   = init_s_addr_i;
        s_wrdata_o = init_s_wrdata_i;
        s_wren_o   = init_s_wren_i;
      end
      OWN_KSA: begin
        s_addr_o   = ksa_s_addr_i;
        s_wrdata_o = ksa_s_wrdata_i;
        s_wren_o   = ksa_s_wren_i;
      end
      OWN_PRGA: begin
        s_addr_o   = prga_s_addr_i;
        s_wrdata_o = prga_s_wrdata_i;
        s_wren_o   = prga_s_wren_i;
      end
      default: begin
        s_addr_o   = '0;
        s_wrdata_o = '0;
        s_wren_o   = 1'b0;
      end
    endcase
  end

  // Next-state logic; a watchdog abort only applies when the phase did not exit.
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    key_d   = key_q;
    start_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (en_i) begin
          state_d = INIT_GO;
          key_d   = key_i;
          err_d   = 1'b0;
          start_s = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      // ARM gives the engine one cycle to drop rdy after the handshake.
      INIT_ARM, KSA_ARM, PRGA_ARM: state_d = next_of(state_q);
      INIT_GO, KSA_GO, PRGA_GO, INIT_WAIT, KSA_WAIT, PRGA_WAIT: begin
        if (cur_rdy_s) begin
          state_d = next_of(state_q);
        end else if (wd_exp_s) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Sequencer state, error flag and latched key.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      err_q   <= 1'b0;
      key_q   <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      key_q   <= key_d;
    end
  end

`ifdef ARC4_CYCLE_COUNT_EN
  logic [31:0] cyc_q, cyc_d;

  assign cycles_o = cyc_q;

  // Busy-cycle count: cleared at start, saturating, frozen while idle.
  always_comb begin
    if (start_s) begin
      cyc_d = 32'd0;
    end else if ((state_q != IDLE) && (cyc_q != 32'hFFFF_FFFF)) begin
      cyc_d = cyc_q + 32'd1;
    end else begin
      cyc_d = cyc_q;
    end
  end

  // Cycle counter register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cyc_q <= 32'd0;
    end else begin
      cyc_q <= cyc_d;
    end
  end
`endif

endmodule

// File: tb/tb_arc4_seq.sv
// Self-checking bench for arc4_seq. Two instances: dut_a (default TIMEOUT)
// for the normal runs, dut_b (TIMEOUT=16) for the watchdog runs. Stub engines
// accept en while idle, then keep rdy low so each phase lasts 1+N cycles; all
// stubs write continuously with distinct address/data tags.
module tb_arc4_seq;

  logic clk;
  logic rst_n;

  logic        en_a, en_b;
  logic [23:0] key_a, key_b;
  logic        rdy_a, rdy_b, err_a, err_b;
  logic [23:0] keyq_a, keyq_b;
  logic [7:0]  s_addr_a, s_addr_b, s_wrdata_a, s_wrdata_b;
  logic        s_wren_a, s_wren_b;
`ifdef ARC4_CYCLE_COUNT_EN
  logic [31:0] cycles_a, cycles_b;
`endif

  logic [1:0][2:0] eng_en;
  logic [1:0][2:0] eng_rdy;
  int unsigned     n_cfg [2][3];
  bit              hang  [2][3];

  logic [7:0] tag_addr [4] = '{8'h00, 8'h11, 8'h22, 8'h33};
  logic [7:0] tag_data [4] = '{8'h00, 8'hA1, 8'hA2, 8'hA3};

  int n_checks = 0;
  int n_errors = 0;
  int hs_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  arc4_seq dut_a (
    .clk_i(clk), .rst_n_i(rst_n), .en_i(en_a), .rdy_o(rdy_a), .key_i(key_a),
    .err_o(err_a), .key_q_o(keyq_a),
    .init_en_o(eng_en[0][0]), .ksa_en_o(eng_en[0][1]), .prga_en_o(eng_en[0][2]),
    .init_rdy_i(eng_rdy[0][0]), .ksa_rdy_i(eng_rdy[0][1]), .prga_rdy_i(eng_rdy[0][2]),
    .init_s_addr_i(8'h11), .init_s_wrdata_i(8'hA1), .init_s_wren_i(1'b1),
    .ksa_s_addr_i(8'h22), .ksa_s_wrdata_i(8'hA2), .ksa_s_wren_i(1'b1),
    .prga_s_addr_i(8'h33), .prga_s_wrdata_i(8'hA3), .prga_s_wren_i(1'b1),
    .s_addr_o(s_addr_a), .s_wrdata_o(s_wrdata_a), .s_wren_o(s_wren_a)
`ifdef ARC4_CYCLE_COUNT_EN
    , .cycles_o(cycles_a)
`endif
  );

  arc4_seq #(.TIMEOUT(32'd16)) dut_b (
    .clk_i(clk), .rst_n_i(rst_n), .en_i(en_b), .rdy_o(rdy_b), .key_i(key_b),
    .err_o(err_b), .key_q_o(keyq_b),
    .init_en_o(eng_en[1][0]), .ksa_en_o(eng_en[1][1]), .prga_en_o(eng_en[1][2]),
    .init_rdy_i(eng_rdy[1][0]), .ksa_rdy_i(eng_rdy[1][1]), .prga_rdy_i(eng_rdy[1][2]),
    .init_s_addr_i(8'h11), .init_s_wrdata_i(8'hA1), .init_s_wren_i(1'b1),
    .ksa_s_addr_i(8'h22), .ksa_s_wrdata_i(8'hA2), .ksa_s_wren_i(1'b1),
    .prga_s_addr_i(8'h33), .prga_s_wrdata_i(8'hA3), .prga_s_wren_i(1'b1),
    .s_addr_o(s_addr_b), .s_wrdata_o(s_wrdata_b), .s_wren_o(s_wren_b)
`ifdef ARC4_CYCLE_COUNT_EN
    , .cycles_o(cycles_b)
`endif
  );

  // Stub engines: accept en while idle, then stay busy for N-1 cycles.
  for (genvar d = 0; d < 2; d++) begin : g_dut
    for (genvar e = 0; e < 3; e++) begin : g_eng
      int unsigned cnt;
      assign eng_rdy[d][e] = (cnt == 0) && !hang[d][e];
      always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= 0;
        else if (eng_en[d][e] && eng_rdy[d][e]) cnt <= n_cfg[d][e] - 1;
        else if (cnt != 0) cnt <= cnt - 1;
      end
    end
  end

  // Handshake log of dut_a (engine index per accepted en).
  always @(posedge clk) begin
    for (int e = 0; e < 3; e++)
      if (rst_n && eng_en[0][e] && eng_rdy[0][e]) hs_q.push_back(e);
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s obs=%0h exp=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference owner for cycle k after the start edge: INIT for 1+Ni cycles,
  // then KSA for 1+Nk, then PRGA for 1+Np, then idle (0).
  function automatic int exp_owner(int k, int ni, int nk, int np);
    if (k < 1 + ni) return 1;
    else if (k < 2 + ni + nk) return 2;
    else if (k < 3 + ni + nk + np) return 3;
    else return 0;
  endfunction

  task automatic run_a(input logic [23:0] key, input int ni, input int nk,
                       input int np, input bit busy_pulse);
    int total;
    int low;
    int ow;
    n_cfg[0][0] = ni; n_cfg[0][1] = nk; n_cfg[0][2] = np;
    total = 3 + ni + nk + np;
    low = 0;
    @(negedge clk);
    check_eq("rdy_before_start", rdy_a, 1);
    hs_q.delete();
    en_a = 1'b1; key_a = key;
    @(negedge clk);
    en_a = 1'b0; key_a = 24'($urandom);
    for (int k = 0; k < total + 3; k++) begin
      ow = exp_owner(k, ni, nk, np);
      if (!rdy_a) low++;
      check_eq("rdy", rdy_a, (k < total) ? 0 : 1);
      check_eq("s_addr", s_addr_a, tag_addr[ow]);
      check_eq("s_wrdata", s_wrdata_a, tag_data[ow]);
      check_eq("s_wren", s_wren_a, (ow != 0) ? 1 : 0);
      if (busy_pulse && k == ni + 5) begin en_a = 1'b1; key_a = 24'hFFFFFF; end
      if (busy_pulse && k == ni + 6) en_a = 1'b0;
      @(negedge clk);
    end
    check_eq("rdy_low_cycles", low, total);
    check_eq("err", err_a, 0);
    check_eq("key_q", keyq_a, key);
    check_eq("hs_count", hs_q.size(), 3);
    for (int i = 0; i < hs_q.size() && i < 3; i++) check_eq("hs_order", hs_q[i], i);
`ifdef ARC4_CYCLE_COUNT_EN
    check_eq("cycles", cycles_a, total);
`endif
  endtask

  // Watchdog run on dut_b: INIT takes 1+4 cycles, KSA never becomes idle,
  // so the abort lands 16 cycles after KSA entry (k = 21).
  task automatic run_wd(input logic [23:0] key);
    int ow;
    @(negedge clk);
    check_eq("wd_rdy_before", rdy_b, 1);
    en_b = 1'b1; key_b = key;
    @(negedge clk);
    en_b = 1'b0;
    for (int k = 0; k < 26; k++) begin
      ow = (k < 5) ? 1 : ((k < 21) ? 2 : 0);
      check_eq("wd_err", err_b, (k < 21) ? 0 : 1);
      check_eq("wd_rdy", rdy_b, (k < 21) ? 0 : 1);
      check_eq("wd_s_wren", s_wren_b, (k < 21) ? 1 : 0);
      check_eq("wd_s_addr", s_addr_b, tag_addr[ow]);
      @(negedge clk);
    end
    check_eq("wd_key_q", keyq_b, key);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout obs=running exp=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst_n = 1'b0;
    en_a = 1'b0; en_b = 1'b0; key_a = 24'h0; key_b = 24'h0;
    for (int d = 0; d < 2; d++)
      for (int e = 0; e < 3; e++) begin n_cfg[d][e] = 2; hang[d][e] = 1'b0; end
    repeat (3) @(negedge clk);
    check_eq("rst_rdy", rdy_a, 1);
    check_eq("rst_err", err_a, 0);
    check_eq("rst_key_q", keyq_a, 0);
    check_eq("rst_en", eng_en, 0);
    check_eq("rst_s_wren", s_wren_a, 0);
    check_eq("rst_s_addr", s_addr_a, 0);
    rst_n = 1'b1;

    // happy path, then start attempt while busy
    run_a(24'h000018, 256, 768, 200, 1'b0);
    run_a(24'h00A5C3, 20, 40, 20, 1'b1);
    // random durations and keys, plus the minimum durations
    repeat (4) run_a(24'($urandom), $urandom_range(2, 40), $urandom_range(2, 40),
                     $urandom_range(2, 40), 1'b0);
    run_a(24'($urandom), 2, 2, 2, 1'b0);

    // watchdog abort twice; the second start must clear err
    n_cfg[1][0] = 4; n_cfg[1][2] = 4; hang[1][1] = 1'b1;
    run_wd(24'h123456);
    check_eq("wd_err_sticky", err_b, 1);
    run_wd(24'h654321);

    // asynchronous reset in the middle of PRGA (PRGA spans k = 22..72)
    n_cfg[0][0] = 10; n_cfg[0][1] = 10; n_cfg[0][2] = 50;
    @(negedge clk);
    en_a = 1'b1; key_a = 24'h00BEEF;
    @(negedge clk);
    en_a = 1'b0;
    repeat (32) @(negedge clk);
    check_eq("pre_rst_owner", s_addr_a, 8'h33);
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_rdy", rdy_a, 1);
    check_eq("mid_rst_en", eng_en, 0);
    check_eq("mid_rst_s_wren", s_wren_a, 0);
    check_eq("mid_rst_key_q", keyq_a, 0);
    @(negedge clk);
    rst_n = 1'b1;
    hang[1][1] = 1'b0;
    run_a(24'h000018, 256, 768, 200, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
